// File: rtl/lfsr_prbs_checker.sv
// Serial PRBS checker: self-seeds from the received bits, locks after LOCK_CNT good predictions,
// then counts bit errors. Define LFSR_CHK_RELOCK_EN to enable loss-of-lock and automatic re-seed.
module lfsr_prbs_checker #(
   parameter int unsigned      WIDTH       = 16,
   parameter logic [WIDTH-1:0] TAPS        = 16'hB400,
   parameter int unsigned      LOCK_CNT    = 32,
   parameter int unsigned      WINDOW      = 256,
   parameter int unsigned      LOSS_THRESH = 8,
   parameter int unsigned      ERR_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             in_bit,
   input  logic             clr_cnt,
   output logic             locked,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_count,
   output logic [1:0]       state_o
);

   localparam int unsigned SEED_W  = $clog2(WIDTH + 1);
   localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
   localparam logic [SEED_W-1:0]  SEED_LAST  = SEED_W'(WIDTH - 1);
   localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);

   if (WIDTH < 4 || WINDOW < 2 || (WINDOW & (WINDOW - 1)) != 0 || LOSS_THRESH == 0 ||
       LOCK_CNT == 0) begin : g_param_check
      $error("lfsr_prbs_checker: illegal parameter set");
   end

   typedef enum logic [1:0] {
      StSeed   = 2'd0,
      StVerify = 2'd1,
      StLocked = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   lfsr_q, lfsr_d;
   logic [SEED_W-1:0]  seed_cnt_q, seed_cnt_d;
   logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
   logic [ERR_W-1:0]   err_count_q, err_count_d;
   logic               err_pulse_q, err_pulse_d;

   logic pred;
   logic mismatch;
   logic loss;

   assign pred     = ^(lfsr_q & TAPS);
   assign mismatch = in_bit ^ pred;

`ifdef LFSR_CHK_RELOCK_EN
   localparam int unsigned WIN_W  = $clog2(WINDOW);
   localparam int unsigned WERR_W = $clog2(LOSS_THRESH + 1);
   localparam logic [WIN_W-1:0]  WIN_LAST    = WIN_W'(WINDOW - 1);
   localparam logic [WERR_W-1:0] THRESH_LAST = WERR_W'(LOSS_THRESH - 1);

   logic [WIN_W-1:0]  win_bit_q, win_bit_d;
   logic [WERR_W-1:0] win_err_q, win_err_d;

   // An error landing on the window's last bit still counts toward the closing window.
   assign loss = in_valid && (state_q == StLocked) && mismatch && (win_err_q == THRESH_LAST);

   always_comb begin
      win_bit_d = win_bit_q;
      win_err_d = win_err_q;
      if (state_q != StLocked || loss) begin
         win_bit_d = '0;
         win_err_d = '0;
      end else if (in_valid) begin
         win_bit_d = win_bit_q + 1'b1;
         if (win_bit_q == WIN_LAST) begin
            win_err_d = '0;
         end else if (mismatch) begin
            win_err_d = win_err_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_bit_q <= '0;
         win_err_q <= '0;
      end else begin
         win_bit_q <= win_bit_d;
         win_err_q <= win_err_d;
      end
   end
`else
   assign loss = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      lfsr_d      = lfsr_q;
      seed_cnt_d  = seed_cnt_q;
      match_cnt_d = match_cnt_q;
      err_count_d = err_count_q;
      err_pulse_d = 1'b0;
      if (in_valid) begin
         case (state_q)
            StSeed: begin
               lfsr_d = {lfsr_q[WIDTH-2:0], in_bit};
               if (seed_cnt_q == SEED_LAST) begin
                  seed_cnt_d = '0;
                  // An all-zero load would lock the LFSR up, so keep seeding.
                  if (lfsr_d != '0) begin
                     state_d     = StVerify;
                     match_cnt_d = '0;
                  end
               end else begin
                  seed_cnt_d = seed_cnt_q + 1'b1;
               end
            end
            StVerify: begin
               lfsr_d = {lfsr_q[WIDTH-2:0], pred};
               if (mismatch) begin
                  state_d     = StSeed;
                  seed_cnt_d  = '0;
                  match_cnt_d = '0;
               end else if (match_cnt_q == MATCH_LAST) begin
                  state_d     = StLocked;
                  match_cnt_d = '0;
               end else begin
                  match_cnt_d = match_cnt_q + 1'b1;
               end
            end
            StLocked: begin
               lfsr_d = {lfsr_q[WIDTH-2:0], pred};
               if (mismatch) begin
                  err_pulse_d = 1'b1;
                  if (err_count_q != '1) begin
                     err_count_d = err_count_q + 1'b1;
                  end
               end
            end
            default: begin
               state_d = StSeed;
            end
         endcase
         if (loss) begin
            state_d    = StSeed;
            seed_cnt_d = '0;
         end
      end
      if (clr_cnt) begin
         err_count_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StSeed;
         lfsr_q      <= '0;
         seed_cnt_q  <= '0;
         match_cnt_q <= '0;
         err_count_q <= '0;
         err_pulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         lfsr_q      <= lfsr_d;
         seed_cnt_q  <= seed_cnt_d;
         match_cnt_q <= match_cnt_d;
         err_count_q <= err_count_d;
         err_pulse_q <= err_pulse_d;
      end
   end

   assign locked    = (state_q == StLocked);
   assign err_pulse = err_pulse_q;
   assign err_count = err_count_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// Bench for lfsr_prbs_checker: directed scenarios plus a randomized run, all checked
// against a bit-history reference model. Honours LFSR_CHK_RELOCK_EN like the design.
module tb_lfsr_prbs_checker;

   localparam int          WIDTH       = 16;
   localparam logic [15:0] TAPS        = 16'hB400;
   localparam int          LOCK_CNT    = 32;
   localparam int          WINDOW      = 256;
   localparam int          LOSS_THRESH = 8;
   localparam int          ERR_W       = 16;
`ifdef LFSR_CHK_RELOCK_EN
   localparam bit RELOCK = 1'b1;
`else
   localparam bit RELOCK = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_bit;
   logic             clr_cnt;
   logic             locked;
   logic             err_pulse;
   logic [ERR_W-1:0] err_count;
   logic [1:0]       state_o;

   int checks = 0;
   int errors = 0;

   logic [15:0] gen;
   logic [15:0] taps_v;

   // Reference model: hist[i] is the bit shifted in i steps ago.
   bit hist[$];
   int m_state;
   int m_seed_n;
   int m_match_n;
   int m_win_bits;
   int m_win_errs;
   int m_errs;
   bit m_pulse;

   lfsr_prbs_checker #(
      .WIDTH      (WIDTH),
      .TAPS       (TAPS),
      .LOCK_CNT   (LOCK_CNT),
      .WINDOW     (WINDOW),
      .LOSS_THRESH(LOSS_THRESH),
      .ERR_W      (ERR_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_bit   (in_bit),
      .clr_cnt  (clr_cnt),
      .locked   (locked),
      .err_pulse(err_pulse),
      .err_count(err_count),
      .state_o  (state_o)
   );

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      hist.delete();
      for (int i = 0; i < WIDTH; i++) hist.push_back(1'b0);
      m_state    = 0;
      m_seed_n   = 0;
      m_match_n  = 0;
      m_win_bits = 0;
      m_win_errs = 0;
      m_errs     = 0;
      m_pulse    = 1'b0;
   endtask

   function automatic bit model_pred();
      bit p = 1'b0;
      for (int i = 0; i < WIDTH; i++) if (taps_v[i]) p ^= hist[i];
      return p;
   endfunction

   task automatic model_push(input bit x);
      hist.push_front(x);
      void'(hist.pop_back());
   endtask

   task automatic model_step(input bit v, input bit b, input bit c);
      bit p;
      bit all_zero;
      m_pulse = 1'b0;
      if (v) begin
         p = model_pred();
         if (m_state == 0) begin
            model_push(b);
            m_seed_n++;
            if (m_seed_n == WIDTH) begin
               m_seed_n = 0;
               all_zero = 1'b1;
               foreach (hist[i]) if (hist[i]) all_zero = 1'b0;
               if (!all_zero) begin
                  m_state   = 1;
                  m_match_n = 0;
               end
            end
         end else if (m_state == 1) begin
            model_push(p);
            if (b != p) begin
               m_state   = 0;
               m_seed_n  = 0;
               m_match_n = 0;
            end else begin
               m_match_n++;
               if (m_match_n == LOCK_CNT) begin
                  m_state    = 2;
                  m_win_bits = 0;
                  m_win_errs = 0;
               end
            end
         end else begin
            model_push(p);
            if (b != p) begin
               m_pulse = 1'b1;
               if (m_errs < (1 << ERR_W) - 1) m_errs++;
               m_win_errs++;
            end
            m_win_bits++;
            if (RELOCK && m_win_errs >= LOSS_THRESH) begin
               m_state  = 0;
               m_seed_n = 0;
            end
            if (m_win_bits == WINDOW) begin
               m_win_bits = 0;
               m_win_errs = 0;
            end
         end
      end
      if (c) m_errs = 0;
   endtask

   task automatic cmp_all(input string tag);
      check({tag, ".state"},     32'(state_o),   32'(m_state));
      check({tag, ".locked"},    32'(locked),    32'(m_state == 2));
      check({tag, ".err_pulse"}, 32'(err_pulse), 32'(m_pulse));
      check({tag, ".err_count"}, 32'(err_count), 32'(m_errs));
   endtask

   task automatic cycle(input bit v, input bit b, input bit c);
      in_valid = v;
      in_bit   = b;
      clr_cnt  = c;
      @(posedge clk);
      #1;
      model_step(v, b, c);
      cmp_all("cyc");
   endtask

   task automatic gen_bit(output bit b);
      b   = ^(gen & taps_v);
      gen = {gen[14:0], b};
   endtask

   task automatic send(input bit flip);
      bit b;
      gen_bit(b);
      cycle(1'b1, b ^ flip, 1'b0);
   endtask

   // Reset is raised between edges so its asynchronous effect is visible before any clock.
   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b0;
      in_bit   = 1'b0;
      clr_cnt  = 1'b0;
      #1;
      model_reset();
      cmp_all("async_rst");
      @(posedge clk);
      #1;
      rst = 1'b0;
      cmp_all("rst_release");
   endtask

   function automatic logic [15:0] rand_seed();
      logic [15:0] s = 16'($urandom);
      if (s == 16'h0) s = 16'h1;
      return s;
   endfunction

   initial begin
      bit b;
      int vcount;
      taps_v   = TAPS;
      rst      = 1'b0;
      in_valid = 1'b0;
      in_bit   = 1'b0;
      clr_cnt  = 1'b0;

      // Clean stream from seed 1: lock after exactly 48 valid bits, no errors over 10000.
      do_reset();
      gen = 16'h0001;
      for (int i = 0; i < WIDTH + LOCK_CNT; i++) begin
         send(1'b0);
         if (i == WIDTH + LOCK_CNT - 2) check("lock_early", 32'(locked), 32'd0);
      end
      check("lock_48", 32'(locked), 32'd1);
      for (int i = WIDTH + LOCK_CNT; i < 10000; i++) send(1'b0);
      check("clean_err_count", 32'(err_count), 32'd0);

      // Single flipped bit while locked.
      send(1'b1);
      check("single_pulse", 32'(err_pulse), 32'd1);
      check("single_count", 32'(err_count), 32'd1);
      send(1'b0);
      check("single_pulse_end", 32'(err_pulse), 32'd0);
      check("single_locked", 32'(locked), 32'd1);

      // Eight errors inside one window, starting at a window boundary.
      gen_bit(b);
      cycle(1'b1, b, 1'b1);
      for (int i = 0; i < WINDOW && m_win_bits != 0; i++) send(1'b0);
      for (int k = 0; k < LOSS_THRESH; k++) begin
         send(1'b1);
         if (k != LOSS_THRESH - 1) for (int j = 0; j < 9; j++) send(1'b0);
      end
      check("loss_locked", 32'(locked), RELOCK ? 32'd0 : 32'd1);
      check("loss_count", 32'(err_count), 32'd8);
`ifdef LFSR_CHK_RELOCK_EN
      for (int i = 0; i < WIDTH + LOCK_CNT; i++) begin
         send(1'b0);
         if (i == WIDTH + LOCK_CNT - 2) check("relock_early", 32'(locked), 32'd0);
      end
      check("relock_48", 32'(locked), 32'd1);
      check("relock_count", 32'(err_count), 32'd8);
`endif

      // All-zero seed is rejected and seeding restarts.
      do_reset();
      for (int i = 0; i < WIDTH; i++) cycle(1'b1, 1'b0, 1'b0);
      check("zero_seed_state", 32'(state_o), 32'd0);
      check("zero_seed_locked", 32'(locked), 32'd0);
      gen = rand_seed();
      for (int i = 0; i < WIDTH + LOCK_CNT; i++) send(1'b0);
      check("zero_seed_lock", 32'(locked), 32'd1);

      // Inverted bit 20 during VERIFY: back to SEED, lock at bit 68.
      do_reset();
      gen = rand_seed();
      for (int i = 0; i <= 20 + WIDTH + LOCK_CNT; i++) begin
         send(i == 20);
         if (i == 20) check("verify_err_state", 32'(state_o), 32'd0);
         if (i == 19 + WIDTH + LOCK_CNT) check("verify_lock_early", 32'(locked), 32'd0);
      end
      check("verify_lock", 32'(locked), 32'd1);
      check("verify_err_count", 32'(err_count), 32'd0);

      // Five errors, then clear coinciding with a sixth mismatch.
      for (int k = 0; k < 5; k++) begin
         send(1'b1);
         for (int j = 0; j < 9; j++) send(1'b0);
      end
      check("five_count", 32'(err_count), 32'd5);
      gen_bit(b);
      cycle(1'b1, ~b, 1'b1);
      check("clr_prio_count", 32'(err_count), 32'd0);
      check("clr_prio_pulse", 32'(err_pulse), 32'd1);

      // 50% in_valid: lock latency counts valid bits only.
      do_reset();
      gen    = rand_seed();
      vcount = 0;
      for (int i = 0; i < 2000 && vcount < WIDTH + LOCK_CNT; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            send(1'b0);
            vcount++;
            if (vcount == WIDTH + LOCK_CNT - 1) check("gap_lock_early", 32'(locked), 32'd0);
         end else begin
            cycle(1'b0, 1'($urandom), 1'b0);
         end
      end
      check("gap_lock", 32'(locked), 32'd1);
      check("gap_valid_bits", 32'(vcount), 32'(WIDTH + LOCK_CNT));

      // Randomized traffic: gaps, sparse bit errors and occasional clears.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 3) != 0) begin
            gen_bit(b);
            cycle(1'b1, b ^ ($urandom_range(0, 39) == 0), $urandom_range(0, 199) == 0);
         end else begin
            cycle(1'b0, 1'($urandom), 1'b0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
